fpu_comp_pipe: RTL and testbench
================================

Name: fpu_comp_pipe

Overview:
Parametrised, pipelined IEEE-754 comparator and min/max unit for the FPU datapath. It supports arbitrary exponent and fraction widths; the default is fp16. It adds NaN/unordered detection, signed-zero equality, signalling-compare exceptions and MIN/MAX selection. A valid/ready handshake lets it sit between the operand issue stage and the FPU writeback arbiter with full back-pressure.

Parameters:
EXP_W, 5, exponent field width
FRAC_W, 10, fraction field width (W = 1+EXP_W+FRAC_W)

Ports:
clock  input  1  single clock, rising edge
reset  input  1  synchronous, active-high reset
in_valid  input  1  operand pair valid
in_ready  output  1  unit can accept operands this cycle
op  input  3  comp_op_t: 0 EQ, 1 LT, 2 LE, 3 MIN, 4 MAX, 5-7 reserved
a, b  input  W  operands {sign, exp, frac}
out_valid  output  1  result valid
out_ready  input  1  consumer accepts result
result  output  W  MIN/MAX value; compare ops give {W-1 zeros, outcome bit}
lt, eq, gt  output  1  ordered relation a?b (all 0 if unordered)
unordered  output  1  at least one operand is NaN
invalid  output  1  IEEE invalid-operation flag

Behaviour:
- Transfer: input when in_valid&in_ready; output when out_valid&out_ready.
- Two register stages, S1 and S2:
  - S1 captures a, b, op and classification (isNaN, isSNaN, isZero per operand).
  - S2 holds compare/select results. All outputs are driven directly from S2 registers.
- Latency: 2 cycles from input transfer to out_valid with no stall. Throughput is 1 per cycle.
- Stall logic:
  - adv2 = ~s2_valid | out_ready
  - adv1 = ~s1_valid | adv2
  - in_ready = adv1 (combinational, no input→in_ready path other than through out_ready)
- While out_valid&~out_ready, every output is held stable. No bubbles are inserted when out_ready is high.
- Reset: s1_valid=s2_valid=0; result=0; lt=eq=gt=unordered=invalid=0; out_valid=0. in_ready=1 in the first cycle after reset. Input presented during a reset cycle is dropped. Reset mid-operation discards all in-flight entries.
- Classification:
  - NaN = exp all ones & frac≠0.
  - sNaN = NaN & frac MSB=0.
  - Zero = exp=0 & frac=0.
- Ordered compare:
  - +0 and -0 compare equal (eq=1).
  - Otherwise use sign/magnitude: both positive → magnitude order; both negative → reversed order; mixed signs → the negative operand is less.
  - Infinities order naturally.
- Unordered (either operand NaN): lt=eq=gt=0, unordered=1.
- invalid:
  - Set for any sNaN, all ops.
  - Set for any NaN (quiet or signalling) with op LT or LE.
  - EQ with only qNaN operands does not set invalid.
- result per op:
  - EQ → eq.
  - LT → lt.
  - LE → lt|eq (0 if unordered).
- MIN/MAX:
  - Return the smaller/larger operand.
  - min(±0, ∓0) = -0; max = +0.
  - Exactly one NaN → return the other operand.
  - Both NaN → canonical qNaN {0, all-ones exp, frac MSB=1, rest 0}.
  - invalid per sNaN rule.
- Reserved op: result=0, lt/eq/gt/unordered computed normally, invalid=1.
- lt/eq/gt/unordered are always valid alongside any op.

Decomposition:
- fpu_pkg additions:
  - Parametrised format helpers: fp16_t retained, plus field-width localparams.
  - comp_op_t enum (3-bit).
  - comp_flags_t struct {lt, eq, gt, unordered, invalid}.
  - Canonical-qNaN constant function of EXP_W/FRAC_W.
- One combinational sub-module, fpu_comp_core: parametrised classify+compare+select, instantiated between S1 and S2. The top holds only pipeline registers and handshake.

Test Plan:
- Reset then stream EQ(0x3C00,0x3C00), LT(0x3C00,0x4000), MAX(0xBC00,0x3C00) with out_ready=1 → out_valid cycles 2,3,4. Results are 1 (eq=1), 1 (lt=1), 0x3C00 (lt=1).
- Signed zero:
  - EQ(0x0000,0x8000) → result=1, eq=1.
  - MIN(0x0000,0x8000) → 0x8000.
  - MAX(0x8000,0x0000) → 0x0000.
- NaN handling:
  - EQ(0x7E00,0x3C00) → result 0, unordered=1, invalid=0.
  - LT(0x7E00,0x3C00) → invalid=1.
  - MIN(0x7D00,0x4000) → 0x4000, invalid=1.
  - MAX(0x7E00,0x7E01) → 0x7E00, invalid=0.
- Back-pressure:
  - Issue 4 ops back-to-back and hold out_ready=0 from cycle 2.
  - in_ready deasserts once S1 and S2 are full; outputs stay stable.
  - Release → all 4 results emerge in order, none lost or duplicated.
- Ordering edges:
  - LE(0xFC00,0xC000) → 1.
  - LT(0x4000,0x7C00) → 1.
  - GT relation for (0xC000,0xC400) → gt=1.
  - Reserved op 6 → result 0, invalid=1.
- Reset mid-stream with two entries in flight → out_valid=0 the next cycle, no stale result emitted. Also rerun the first scenario with EXP_W=8, FRAC_W=23 on fp32 values 0x3F800000 vs 0x40000000.

Source files
------------

// File: rtl/fpu_pkg.sv
// Shared FPU definitions: format widths, comparator opcodes/flags and the
// canonical quiet-NaN pattern for any exponent/fraction width.
package fpu_pkg;

  localparam int FP16_EXP_W  = 5;
  localparam int FP16_FRAC_W = 10;
  localparam int FP16_W      = 1 + FP16_EXP_W + FP16_FRAC_W;

  typedef logic [FP16_W-1:0] fp16_t;

  typedef enum logic [2:0] {
    CMP_EQ  = 3'd0,
    CMP_LT  = 3'd1,
    CMP_LE  = 3'd2,
    CMP_MIN = 3'd3,
    CMP_MAX = 3'd4
  } comp_op_t;

  typedef struct packed {
    logic lt;
    logic eq;
    logic gt;
    logic unordered;
    logic invalid;
  } comp_flags_t;

  // {0, all-ones exponent, fraction MSB set}, right-aligned in 64 bits.
  function automatic logic [63:0] canon_qnan(input int exp_w, input int frac_w);
    return (((64'd1 << exp_w) - 64'd1) << frac_w) | (64'd1 << (frac_w - 1));
  endfunction

endpackage

// File: rtl/fpu_comp_core.sv
// Combinational compare/select core: orders two pre-classified operands and
// produces the per-op result plus relation and exception flags.
module fpu_comp_core
  import fpu_pkg::*;
#(
  parameter int EXP_W  = FP16_EXP_W,
  parameter int FRAC_W = FP16_FRAC_W
) (
  input  logic [EXP_W+FRAC_W:0] a,
  input  logic [EXP_W+FRAC_W:0] b,
  input  logic [2:0]            op,
  input  logic                  a_nan,
  input  logic                  a_snan,
  input  logic                  a_zero,
  input  logic                  b_nan,
  input  logic                  b_snan,
  input  logic                  b_zero,
  output logic [EXP_W+FRAC_W:0] result,
  output comp_flags_t           flags
);

  localparam int W = 1 + EXP_W + FRAC_W;
  localparam logic [63:0] QNAN64 = canon_qnan(EXP_W, FRAC_W);
  localparam logic [W-1:0] QNAN = QNAN64[W-1:0];

  logic mag_lt;
  logic mag_eq;

  always_comb begin
    mag_lt = a[W-2:0] < b[W-2:0];
    mag_eq = a[W-2:0] == b[W-2:0];
    flags  = '0;
    result = '0;

    flags.unordered = a_nan | b_nan;
    if (!flags.unordered) begin
      if (a_zero && b_zero) begin
        flags.eq = 1'b1;
      end else if (a[W-1] != b[W-1]) begin
        flags.lt = a[W-1];
        flags.gt = b[W-1];
      end else if (mag_eq) begin
        flags.eq = 1'b1;
      end else if (a[W-1]) begin
        // both negative: larger magnitude is the smaller value
        flags.lt = ~mag_lt;
        flags.gt = mag_lt;
      end else begin
        flags.lt = mag_lt;
        flags.gt = ~mag_lt;
      end
    end

    flags.invalid = a_snan | b_snan
                  | (flags.unordered && (op == CMP_LT || op == CMP_LE))
                  | (op > CMP_MAX);

    case (op)
      CMP_EQ:  result = W'(flags.eq);
      CMP_LT:  result = W'(flags.lt);
      CMP_LE:  result = W'(flags.lt | flags.eq);
      CMP_MIN, CMP_MAX: begin
        if (a_nan && b_nan)      result = QNAN;
        else if (a_nan)          result = b;
        else if (b_nan)          result = a;
        else if (a_zero && b_zero)
          // OR keeps a set sign bit (-0 wins), AND clears it (+0 wins)
          result = (op == CMP_MIN) ? (a | b) : (a & b);
        else if (op == CMP_MIN)  result = flags.gt ? b : a;
        else                     result = flags.lt ? b : a;
      end
      default: result = '0;
    endcase
  end

endmodule

// File: rtl/fpu_comp_pipe.sv
// Two-stage IEEE-754 comparator / min-max unit with valid/ready back-pressure;
// S1 registers operands and their classification, S2 registers the outcome.
module fpu_comp_pipe
  import fpu_pkg::*;
#(
  parameter int EXP_W  = FP16_EXP_W,
  parameter int FRAC_W = FP16_FRAC_W
) (
  input  logic                  clock,
  input  logic                  reset,
  input  logic                  in_valid,
  output logic                  in_ready,
  input  logic [2:0]            op,
  input  logic [EXP_W+FRAC_W:0] a,
  input  logic [EXP_W+FRAC_W:0] b,
  output logic                  out_valid,
  input  logic                  out_ready,
  output logic [EXP_W+FRAC_W:0] result,
  output logic                  lt,
  output logic                  eq,
  output logic                  gt,
  output logic                  unordered,
  output logic                  invalid
);

  localparam int W = 1 + EXP_W + FRAC_W;

  // {nan, snan, zero}
  function automatic logic [2:0] classify(input logic [W-1:0] x);
    logic exp_ones, exp_zero, frac_zero;
    exp_ones  = &x[W-2:FRAC_W];
    exp_zero  = ~|x[W-2:FRAC_W];
    frac_zero = ~|x[FRAC_W-1:0];
    return {exp_ones & ~frac_zero, exp_ones & ~frac_zero & ~x[FRAC_W-1], exp_zero & frac_zero};
  endfunction

  logic            adv1, adv2;
  logic            vld_p1_q, vld_p1_d;
  logic [W-1:0]    a_p1_q, a_p1_d, b_p1_q, b_p1_d;
  logic [2:0]      op_p1_q, op_p1_d;
  logic [2:0]      cls_a_p1_q, cls_a_p1_d, cls_b_p1_q, cls_b_p1_d;
  logic            vld_p2_q, vld_p2_d;
  logic [W-1:0]    result_p2_q, result_p2_d;
  comp_flags_t     flags_p2_q, flags_p2_d;
  logic [W-1:0]    core_result;
  comp_flags_t     core_flags;

  always_comb begin
    adv2 = ~vld_p2_q | out_ready;
    adv1 = ~vld_p1_q | adv2;

    // S1: operand capture and classification
    vld_p1_d   = adv1 ? in_valid : vld_p1_q;
    a_p1_d     = a_p1_q;
    b_p1_d     = b_p1_q;
    op_p1_d    = op_p1_q;
    cls_a_p1_d = cls_a_p1_q;
    cls_b_p1_d = cls_b_p1_q;
    if (adv1 && in_valid) begin
      a_p1_d     = a;
      b_p1_d     = b;
      op_p1_d    = op;
      cls_a_p1_d = classify(a);
      cls_b_p1_d = classify(b);
    end

    // S2: compare/select outcome, held while the consumer stalls
    vld_p2_d    = adv2 ? vld_p1_q : vld_p2_q;
    result_p2_d = result_p2_q;
    flags_p2_d  = flags_p2_q;
    if (adv2 && vld_p1_q) begin
      result_p2_d = core_result;
      flags_p2_d  = core_flags;
    end
  end

  fpu_comp_core #(.EXP_W(EXP_W), .FRAC_W(FRAC_W)) u_core (
    .a      (a_p1_q),
    .b      (b_p1_q),
    .op     (op_p1_q),
    .a_nan  (cls_a_p1_q[2]),
    .a_snan (cls_a_p1_q[1]),
    .a_zero (cls_a_p1_q[0]),
    .b_nan  (cls_b_p1_q[2]),
    .b_snan (cls_b_p1_q[1]),
    .b_zero (cls_b_p1_q[0]),
    .result (core_result),
    .flags  (core_flags)
  );

  always_ff @(posedge clock) begin
    if (reset) begin
      vld_p1_q    <= 1'b0;
      vld_p2_q    <= 1'b0;
      result_p2_q <= '0;
      flags_p2_q  <= '0;
    end else begin
      vld_p1_q    <= vld_p1_d;
      vld_p2_q    <= vld_p2_d;
      result_p2_q <= result_p2_d;
      flags_p2_q  <= flags_p2_d;
    end
  end

  always_ff @(posedge clock) begin
    a_p1_q     <= a_p1_d;
    b_p1_q     <= b_p1_d;
    op_p1_q    <= op_p1_d;
    cls_a_p1_q <= cls_a_p1_d;
    cls_b_p1_q <= cls_b_p1_d;
  end

  assign in_ready  = adv1;
  assign out_valid = vld_p2_q;
  assign result    = result_p2_q;
  assign lt        = flags_p2_q.lt;
  assign eq        = flags_p2_q.eq;
  assign gt        = flags_p2_q.gt;
  assign unordered = flags_p2_q.unordered;
  assign invalid   = flags_p2_q.invalid;

endmodule

// File: tb/tb_fpu_comp_pipe.sv
// Scoreboard bench for fpu_comp_pipe: fp16 and fp32 instances, directed
// scenarios plus a short special-value sweep, checked against a key-order model.
module tb_fpu_comp_pipe;
  import fpu_pkg::*;

  logic clk = 1'b0;
  always #5 clk = ~clk;

  int cyc = 0;
  always @(posedge clk) cyc <= cyc + 1;

  logic        rst;
  logic        iv16, ir16, ov16, or16, lt16, eq16, gt16, un16, inv16;
  logic [2:0]  op16;
  fp16_t       a16, b16, res16;
  logic        iv32, ir32, ov32, or32, lt32, eq32, gt32, un32, inv32;
  logic [2:0]  op32;
  logic [31:0] a32, b32, res32;

  fpu_comp_pipe dut16 (
    .clock(clk), .reset(rst), .in_valid(iv16), .in_ready(ir16), .op(op16),
    .a(a16), .b(b16), .out_valid(ov16), .out_ready(or16), .result(res16),
    .lt(lt16), .eq(eq16), .gt(gt16), .unordered(un16), .invalid(inv16)
  );

  fpu_comp_pipe #(.EXP_W(8), .FRAC_W(23)) dut32 (
    .clock(clk), .reset(rst), .in_valid(iv32), .in_ready(ir32), .op(op32),
    .a(a32), .b(b32), .out_valid(ov32), .out_ready(or32), .result(res32),
    .lt(lt32), .eq(eq32), .gt(gt32), .unordered(un32), .invalid(inv32)
  );

  typedef struct {
    logic [63:0] res;
    logic [4:0]  flg;   // {lt, eq, gt, unordered, invalid}
    int          in_cyc;
    bit          chk_lat;
  } exp_t;

  exp_t q16[$];
  exp_t q32[$];
  int vectors = 0;
  int miscompares = 0;

  task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] expv);
    vectors++;
    assert (obs === expv) else begin
      miscompares++;
      $error("FAIL %s: observed %h expected %h", tag, obs, expv);
    end
  endtask

  // Reference: map each value to a signed integer key whose order is the
  // numeric order (both zeros map to 0), then derive everything from keys.
  function automatic exp_t model(input logic [2:0] op, input logic [63:0] a, input logic [63:0] b,
                                 input int ew, input int fw);
    exp_t e;
    int w;
    logic [63:0] emask, fmask, mmask, qn, r;
    logic an, bn, asn, bsn, l, q, g, u, iv;
    longint ka, kb;
    w     = 1 + ew + fw;
    emask = (64'd1 << ew) - 64'd1;
    fmask = (64'd1 << fw) - 64'd1;
    mmask = (64'd1 << (w - 1)) - 64'd1;
    an  = (((a >> fw) & emask) == emask) && ((a & fmask) != 64'd0);
    bn  = (((b >> fw) & emask) == emask) && ((b & fmask) != 64'd0);
    asn = an && (((a >> (fw - 1)) & 64'd1) == 64'd0);
    bsn = bn && (((b >> (fw - 1)) & 64'd1) == 64'd0);
    ka  = a[w-1] ? -longint'(a & mmask) : longint'(a & mmask);
    kb  = b[w-1] ? -longint'(b & mmask) : longint'(b & mmask);
    u   = an | bn;
    l   = !u && (ka < kb);
    g   = !u && (ka > kb);
    q   = !u && (ka == kb);
    iv  = asn | bsn | (u && (op == 3'd1 || op == 3'd2)) | (op > 3'd4);
    qn  = (emask << fw) | (64'd1 << (fw - 1));
    case (op)
      3'd0: r = 64'(q);
      3'd1: r = 64'(l);
      3'd2: r = 64'(l | q);
      3'd3, 3'd4: begin
        if (an && bn)    r = qn;
        else if (an)     r = b;
        else if (bn)     r = a;
        else if (q)      r = (op == 3'd3) ? (a[w-1] ? a : b) : (a[w-1] ? b : a);
        else if (op == 3'd3) r = (ka < kb) ? a : b;
        else             r = (ka > kb) ? a : b;
      end
      default: r = 64'd0;
    endcase
    e.res = r;
    e.flg = {l, q, g, u, iv};
    e.in_cyc = 0;
    e.chk_lat = 1'b0;
    return e;
  endfunction

  exp_t m16, m32;
  always @(negedge clk) begin
    if (!rst && ov16 && or16) begin
      if (q16.size() == 0) chk("spurious16_out_valid", 64'(ov16), 64'd0);
      else begin
        m16 = q16.pop_front();
        chk("result16", 64'(res16), m16.res);
        chk("flags16", 64'({lt16, eq16, gt16, un16, inv16}), 64'(m16.flg));
        if (m16.chk_lat) chk("latency16", 64'(cyc - m16.in_cyc), 64'd2);
      end
    end
  end

  always @(negedge clk) begin
    if (!rst && ov32 && or32) begin
      if (q32.size() == 0) chk("spurious32_out_valid", 64'(ov32), 64'd0);
      else begin
        m32 = q32.pop_front();
        chk("result32", 64'(res32), m32.res);
        chk("flags32", 64'({lt32, eq32, gt32, un32, inv32}), 64'(m32.flg));
        if (m32.chk_lat) chk("latency32", 64'(cyc - m32.in_cyc), 64'd2);
      end
    end
  end

  // Called at posedge+1; returns at posedge+1 right after the transfer edge.
  task automatic send(input bit f32, input logic [2:0] o, input logic [63:0] x,
                      input logic [63:0] y, input bit lat);
    exp_t e;
    int n;
    n = 0;
    if (f32) begin op32 = o; a32 = x[31:0]; b32 = y[31:0]; iv32 = 1'b1; end
    else     begin op16 = o; a16 = x[15:0]; b16 = y[15:0]; iv16 = 1'b1; end
    @(negedge clk);
    while (!(f32 ? ir32 : ir16) && n < 40) begin
      @(negedge clk);
      n++;
    end
    chk("in_ready_wait", 64'(n < 40), 64'd1);
    e = model(o, x, y, f32 ? 8 : 5, f32 ? 23 : 10);
    e.in_cyc = cyc;
    e.chk_lat = lat;
    if (f32) q32.push_back(e); else q16.push_back(e);
    @(posedge clk);
    #1;
    if (f32) iv32 = 1'b0; else iv16 = 1'b0;
  endtask

  task automatic drain();
    int n;
    n = 0;
    while ((q16.size() != 0 || q32.size() != 0) && n < 50) begin
      @(negedge clk);
      n++;
    end
    chk("drain_pending", 64'(q16.size() + q32.size()), 64'd0);
    @(posedge clk);
    #1;
  endtask

  initial begin
    #300000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  logic [15:0] sp[10];
  logic [15:0] hold_res;
  logic [4:0]  hold_flg;

  initial begin
    sp = '{16'h0000, 16'h8000, 16'h3C00, 16'hBC00, 16'h7C00,
           16'hFC00, 16'h7E00, 16'h7D00, 16'hFE01, 16'h0001};
    rst = 1'b1;
    iv16 = 1'b0; op16 = '0; a16 = '0; b16 = '0; or16 = 1'b1;
    iv32 = 1'b0; op32 = '0; a32 = '0; b32 = '0; or32 = 1'b1;
    repeat (3) @(posedge clk);
    #1 rst = 1'b0;

    @(negedge clk);
    chk("rst_out_valid", 64'(ov16), 64'd0);
    chk("rst_result", 64'(res16), 64'd0);
    chk("rst_flags", 64'({lt16, eq16, gt16, un16, inv16}), 64'd0);
    chk("rst_in_ready", 64'(ir16), 64'd1);
    chk("rst_out_valid32", 64'(ov32), 64'd0);
    @(posedge clk);
    #1;

    // Basic stream with latency checks
    send(0, CMP_EQ,  64'h3C00, 64'h3C00, 1);
    send(0, CMP_LT,  64'h3C00, 64'h4000, 1);
    send(0, CMP_MAX, 64'hBC00, 64'h3C00, 1);
    drain();

    // Signed zero, NaN handling, ordering edges, reserved op
    send(0, CMP_EQ,  64'h0000, 64'h8000, 1);
    send(0, CMP_MIN, 64'h0000, 64'h8000, 1);
    send(0, CMP_MAX, 64'h8000, 64'h0000, 1);
    send(0, CMP_EQ,  64'h7E00, 64'h3C00, 1);
    send(0, CMP_LT,  64'h7E00, 64'h3C00, 1);
    send(0, CMP_MIN, 64'h7D00, 64'h4000, 1);
    send(0, CMP_MAX, 64'h7E00, 64'h7E01, 1);
    send(0, CMP_LE,  64'hFC00, 64'hC000, 1);
    send(0, CMP_LT,  64'h4000, 64'h7C00, 1);
    send(0, CMP_EQ,  64'hC000, 64'hC400, 1);
    send(0, 3'd6,    64'h3C00, 64'h3C00, 1);
    drain();

    // Back-pressure: four ops, consumer stalls, then releases
    fork
      begin
        send(0, CMP_EQ,  64'h3C00, 64'h3C00, 0);
        send(0, CMP_LT,  64'hC000, 64'h3C00, 0);
        send(0, CMP_LE,  64'h4000, 64'h4000, 0);
        send(0, CMP_MIN, 64'h4400, 64'hC400, 0);
      end
      begin
        @(posedge clk);
        #1 or16 = 1'b0;
        repeat (3) @(negedge clk);
        chk("stall_in_ready", 64'(ir16), 64'd0);
        chk("stall_out_valid", 64'(ov16), 64'd1);
        hold_res = res16;
        hold_flg = {lt16, eq16, gt16, un16, inv16};
        repeat (3) @(negedge clk);
        chk("stall_hold_result", 64'(res16), 64'(hold_res));
        chk("stall_hold_flags", 64'({lt16, eq16, gt16, un16, inv16}), 64'(hold_flg));
        chk("stall_hold_valid", 64'(ov16), 64'd1);
        @(posedge clk);
        #1 or16 = 1'b1;
      end
    join
    drain();

    // Reset with two entries in flight discards them
    or16 = 1'b0;
    send(0, CMP_LT,  64'h3C00, 64'h4000, 0);
    send(0, CMP_MIN, 64'h3C00, 64'h4000, 0);
    rst = 1'b1;
    @(posedge clk);
    #1 rst = 1'b0;
    q16.delete();
    or16 = 1'b1;
    @(negedge clk);
    chk("midrst_out_valid", 64'(ov16), 64'd0);
    chk("midrst_result", 64'(res16), 64'd0);
    chk("midrst_in_ready", 64'(ir16), 64'd1);
    repeat (3) @(negedge clk);
    chk("midrst_no_stale", 64'(ov16), 64'd0);
    @(posedge clk);
    #1;

    // Special-value sweep
    for (int i = 0; i < 30; i++) begin
      send(0, 3'($urandom_range(0, 7)), 64'(sp[$urandom_range(0, 9)]),
           64'(sp[$urandom_range(0, 9)]), 1);
    end
    drain();

    // fp32 instance
    send(1, CMP_EQ,  64'h3F800000, 64'h3F800000, 1);
    send(1, CMP_LT,  64'h3F800000, 64'h40000000, 1);
    send(1, CMP_MAX, 64'hBF800000, 64'h3F800000, 1);
    send(1, CMP_MIN, 64'h00000000, 64'h80000000, 1);
    send(1, CMP_MAX, 64'h7FC00000, 64'h7F800001, 1);
    drain();

    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end

endmodule
